control_in_trace_capture: RTL and testbench
===========================================

# control_in_trace_capture

Synthesizable, parametrised capture block for the LC3 control-stage input bundle (complete_data, complete_instr, IR, NZP, psr, IR_Exec, IMem_dout). It samples the bundle every clock, qualifies samples by a run-time capture mode, timestamps them and buffers them in a DEPTH-entry FIFO drained by a valid/ready port. It sits beside the control unit inputs, feeding an emulation/trace readout path, and records what the control_in monitor BFM observes in simulation.

## Interface
- DATA_W, 16, width of IR, IR_Exec, IMem_dout
- FLAG_W, 3, width of NZP and psr
- DEPTH, 16, FIFO entries; power of two, >= 2
- TS_W, 16, timestamp width
- STOP_ON_FULL, 0, 1: stop capturing on first drop; 0: drop and keep running
- REC_W, TS_W+2+3*DATA_W+2*FLAG_W, record width (derived, not overridable)

Ports:
- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low (asserted at 0)
- start  in  1  pulse: IDLE -> RUN
- stop  in  1  pulse: RUN -> IDLE
- clear  in  1  pulse: flush FIFO, clear status, -> IDLE
- mode  in  2  0 every cycle, 1 on change, 2 on complete_instr, 3 on complete_instr or complete_data
- complete_data, complete_instr  in  1 each  monitored strobes
- IR, IR_Exec, IMem_dout  in  DATA_W each  monitored words
- NZP, psr  in  FLAG_W each  monitored flags
- rd_valid  out  1  FIFO head valid
- rd_ready  in  1  consumer accepts head
- rd_record  out  REC_W  {ts, complete_data, complete_instr, IR, NZP, psr, IR_Exec, IMem_dout}, ts in MSBs
- count  out  $clog2(DEPTH)+1  FIFO occupancy
- overflow  out  1  sticky: at least one qualifying sample dropped
- drop_count  out  8  dropped samples, saturates at 255
- state  out  2  0 IDLE, 1 RUN, 2 STOPPED

## Operation
- Reset: state=IDLE, FIFO empty, rd_valid=0, rd_record=0, count=0, overflow=0, drop_count=0, ts=0, sample stage invalid.
- States: IDLE (no capture), RUN (capture), STOPPED (entered only with STOP_ON_FULL=1 on first drop; no capture; FIFO still drains).
- Control priority per cycle: clear > stop > start. start in RUN ignored. stop in STOPPED -> IDLE. start in STOPPED ignored; clear required.
- start: ts<=0, stage invalid, first-sample flag set. FIFO contents preserved.
- Stage: in RUN each edge registers the bundle plus current ts; stage valid.
- Qualification (on stage contents): mode 0 always; mode 1 if first sample after start or any field differs from previous stage contents (ts excluded); mode 2 complete_instr=1; mode 3 complete_instr|complete_data. mode read live each cycle.
- Write: qualifying valid stage written next edge if FIFO not full, or full with same-cycle pop (rd_valid&rd_ready). Otherwise dropped: overflow<=1, drop_count+1 saturating; STOP_ON_FULL=1 -> state STOPPED.
- ts increments each RUN cycle, wraps 2^TS_W-1 -> 0; holds in IDLE/STOPPED.
- Leaving RUN (stop/clear): sample already in stage still qualified and written on the following edge unless clear.
- clear: FIFO empty, overflow=0, drop_count=0, stage invalid, state IDLE, next edge.
- Read: pop on rd_valid&rd_ready; rd_record stable while rd_valid&!rd_ready.

## Timing
- Latency: bundle at edge k -> stage at k -> FIFO write at k+1 -> rd_valid high after k+1 (empty FIFO); 2 cycles, no bypass.
- Stamp = ts value present during the cycle ending at edge k; first stamp after start is 0.
- Simultaneous push/pop: count unchanged; on empty FIFO push only counts (pop impossible).
- Full throughput: one record per cycle in and out.
- count, overflow, drop_count, state all registered, update on the edge of the event.
- Reset mid-operation: all outputs to reset values immediately (asynchronous), independent of clock.

## Test plan
- Reset release, start, mode 0, rd_ready=1, IR=0x1000+n per cycle for 5 cycles -> 5 records, ts 0..4, IR 0x1000..0x1004, first rd_valid 2 cycles after first sample.
- mode 1, bundle constant 10 cycles, NZP 3'b010->3'b100 at cycle 4 -> exactly 2 records, ts 0 and 4.
- mode 2, DEPTH=4, rd_ready=0, complete_instr high 6 cycles, STOP_ON_FULL=0 -> count=4, overflow=1, drop_count=2, state RUN; clear -> count=0, overflow=0, state IDLE.
- Same with STOP_ON_FULL=1 -> state STOPPED after 5th qualifier, drop_count=1; raise rd_ready -> 4 records drain, state stays STOPPED.
- FIFO full, rd_ready=1, qualifier every cycle -> no drops, count stays DEPTH; stop and start same cycle -> state IDLE.
- reset low mid-RUN with count=3 between edges -> rd_valid, count, state go 0 at once; after release, start restarts ts at 0.

Source files
------------

// File: rtl/control_in_trace_capture.sv
`default_nettype none
// ============================================================================
//  Module      : control_in_trace_capture
//  Description : Trace capture for the LC3 control-stage input bundle.
//                Samples {complete_data, complete_instr, IR, NZP, psr,
//                IR_Exec, IMem_dout} every clock while running, qualifies
//                each sample by the run-time capture mode, stamps it with a
//                free-running timestamp and queues it in a DEPTH-entry FIFO
//                drained over a valid/ready port.
//  Ports       : clock/reset (async, active-low)
//                start/stop/clear  - capture control pulses
//                mode              - 0 all, 1 on change, 2 instr, 3 instr|data
//                complete_*, IR, NZP, psr, IR_Exec, IMem_dout - monitored bundle
//                rd_valid/rd_ready/rd_record - record read port (ts in MSBs)
//                count, overflow, drop_count, state - status
//  Revision    : 1.0 - initial release
// ============================================================================
module control_in_trace_capture #(
    parameter  int DATA_W       = 16,
    parameter  int FLAG_W       = 3,
    parameter  int DEPTH        = 16,
    parameter  int TS_W         = 16,
    parameter  int STOP_ON_FULL = 0,
    localparam int REC_W        = TS_W + 2 + 3*DATA_W + 2*FLAG_W,
    localparam int CNT_W        = $clog2(DEPTH) + 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic              clear,
    input  logic [1:0]        mode,
    input  logic              complete_data,
    input  logic              complete_instr,
    input  logic [DATA_W-1:0] IR,
    input  logic [FLAG_W-1:0] NZP,
    input  logic [FLAG_W-1:0] psr,
    input  logic [DATA_W-1:0] IR_Exec,
    input  logic [DATA_W-1:0] IMem_dout,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [REC_W-1:0]  rd_record,
    output logic [CNT_W-1:0]  count,
    output logic              overflow,
    output logic [7:0]        drop_count,
    output logic [1:0]        state
);

    localparam int         c_AW    = $clog2(DEPTH);
    localparam int         c_BUN_W = 2 + 3*DATA_W + 2*FLAG_W;
    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_RUN     = 2'd1;
    localparam logic [1:0] c_ST_STOPPED = 2'd2;
    localparam logic [CNT_W-1:0] c_FULL = CNT_W'(DEPTH);

    logic [1:0]         r_state;
    logic [TS_W-1:0]    r_ts;
    logic [c_BUN_W-1:0] r_stg_bun;
    logic [c_BUN_W-1:0] r_prv_bun;
    logic [TS_W-1:0]    r_stg_ts;
    logic               r_stg_valid;
    logic               r_stg_first;
    logic               r_first_pend;
    logic [c_AW-1:0]    r_wr_ptr;
    logic [c_AW-1:0]    r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               r_overflow;
    logic [7:0]         r_drop_count;
    logic [REC_W-1:0]   r_mem [0:DEPTH-1];

    logic [c_BUN_W-1:0] w_bundle;
    logic               w_hit;
    logic               w_qual;
    logic               w_full;
    logic               w_pop;
    logic               w_push;
    logic               w_drop;
    logic               w_start_ok;
    logic               w_to_stopped;
    logic [1:0]         w_state_nxt;

    assign w_bundle = {complete_data, complete_instr, IR, NZP, psr, IR_Exec, IMem_dout};

    // Qualification looks at what sits in the stage, with the mode taken live.
    always_comb begin
        w_hit = 1'b0;
        case (mode)
            2'd0:    w_hit = 1'b1;
            2'd1:    w_hit = r_stg_first || (r_stg_bun != r_prv_bun);
            2'd2:    w_hit = r_stg_bun[c_BUN_W-2];
            default: w_hit = r_stg_bun[c_BUN_W-2] | r_stg_bun[c_BUN_W-1];
        endcase
    end

    // A clear discards the staged sample instead of writing it.
    assign w_qual   = r_stg_valid & w_hit & ~clear;
    assign w_full   = (r_count == c_FULL);
    assign rd_valid = (r_count != '0);
    assign w_pop    = rd_valid & rd_ready;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign w_push   = w_qual & (~w_full | w_pop);
    assign w_drop   = w_qual & w_full & ~w_pop;

    assign w_start_ok   = start & ~clear & ~stop & (r_state == c_ST_IDLE);
    assign w_to_stopped = (STOP_ON_FULL != 0) && (r_state == c_ST_RUN) && w_drop && !stop;

    always_comb begin
        w_state_nxt = r_state;
        if (clear || stop) begin
            w_state_nxt = c_ST_IDLE;
        end else if (w_start_ok) begin
            w_state_nxt = c_ST_RUN;
        end else if (w_to_stopped) begin
            w_state_nxt = c_ST_STOPPED;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= c_ST_IDLE;
            r_ts    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_start_ok) begin
                r_ts <= '0;
            end else if (r_state == c_ST_RUN) begin
                r_ts <= r_ts + TS_W'(1);
            end
        end
    end

    // Sample stage. r_prv_bun keeps the previous staged bundle so change
    // detection compares consecutive samples. Entering STOPPED discards the
    // sample taken on the dropping edge, so exactly one drop is recorded.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_stg_bun    <= '0;
            r_prv_bun    <= '0;
            r_stg_ts     <= '0;
            r_stg_valid  <= 1'b0;
            r_stg_first  <= 1'b0;
            r_first_pend <= 1'b0;
        end else if (clear || w_start_ok) begin
            r_stg_valid <= 1'b0;
            if (w_start_ok) begin
                r_first_pend <= 1'b1;
            end
        end else if ((r_state == c_ST_RUN) && !w_to_stopped) begin
            r_stg_bun    <= w_bundle;
            r_prv_bun    <= r_stg_bun;
            r_stg_ts     <= r_ts;
            r_stg_valid  <= 1'b1;
            r_stg_first  <= r_first_pend;
            r_first_pend <= 1'b0;
        end else begin
            r_stg_valid <= 1'b0;
        end
    end

    // FIFO pointers, occupancy and drop bookkeeping.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
        end else if (clear) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CNT_W'(1);
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_count != 8'hFF) begin
                    r_drop_count <= r_drop_count + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {r_stg_ts, r_stg_bun};
        end
    end

    // Storage is not reset; present zero whenever the head is not valid.
    assign rd_record  = rd_valid ? r_mem[r_rd_ptr] : '0;
    assign count      = r_count;
    assign overflow   = r_overflow;
    assign drop_count = r_drop_count;
    assign state      = r_state;

endmodule
`default_nettype wire

// File: tb/tb_control_in_trace_capture.sv
`default_nettype none
// ============================================================================
//  Module      : tb_control_in_trace_capture
//  Description : Directed bench for control_in_trace_capture. Two DEPTH=4
//                instances share stimulus: dut0 drops and keeps running,
//                dut1 stops capturing on the first drop.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_control_in_trace_capture;

    localparam logic [2:0]  c_PSR  = 3'b001;
    localparam logic [15:0] c_IRX  = 16'hABCD;
    localparam logic [15:0] c_IMEM = 16'h1234;

    logic        clock = 1'b0;
    logic        reset, start, stop, clear, rd_ready, cd, ci;
    logic [1:0]  mode;
    logic [15:0] ir, irx, imem;
    logic [2:0]  nzp, psr;

    logic        v0, v1, ov0, ov1;
    logic [71:0] rec0, rec1;
    logic [2:0]  cnt0, cnt1;
    logic [7:0]  dc0, dc1;
    logic [1:0]  st0, st1;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    control_in_trace_capture #(.DEPTH(4), .STOP_ON_FULL(0)) dut0 (
        .clock(clock), .reset(reset), .start(start), .stop(stop), .clear(clear),
        .mode(mode), .complete_data(cd), .complete_instr(ci), .IR(ir), .NZP(nzp),
        .psr(psr), .IR_Exec(irx), .IMem_dout(imem), .rd_valid(v0), .rd_ready(rd_ready),
        .rd_record(rec0), .count(cnt0), .overflow(ov0), .drop_count(dc0), .state(st0)
    );

    control_in_trace_capture #(.DEPTH(4), .STOP_ON_FULL(1)) dut1 (
        .clock(clock), .reset(reset), .start(start), .stop(stop), .clear(clear),
        .mode(mode), .complete_data(cd), .complete_instr(ci), .IR(ir), .NZP(nzp),
        .psr(psr), .IR_Exec(irx), .IMem_dout(imem), .rd_valid(v1), .rd_ready(rd_ready),
        .rd_record(rec1), .count(cnt1), .overflow(ov1), .drop_count(dc1), .state(st1)
    );

    function automatic logic [71:0] rec(input logic [15:0] ts, input logic c_d,
                                        input logic c_i, input logic [15:0] i_r,
                                        input logic [2:0] n);
        return {ts, c_d, c_i, i_r, n, c_PSR, c_IRX, c_IMEM};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        #2;
        if (st0 !== 2'd0) begin n_bad++; $display("FAIL reset_state: got %0d want 0", st0); end
        n_cmp++;
        if (v0 !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", v0); end
        n_cmp++;
        if (rec0 !== 72'h0) begin n_bad++; $display("FAIL reset_record: got %h want 0", rec0); end
        n_cmp++;
        if (cnt0 !== 3'd0 || ov0 !== 1'b0 || dc0 !== 8'd0) begin
            n_bad++; $display("FAIL reset_status: cnt %0d ov %b dc %0d want 0/0/0", cnt0, ov0, dc0);
        end
        n_cmp++;
        @(negedge clock);
        reset = 1'b1;
        tick();
        if (st0 !== 2'd0 || cnt0 !== 3'd0) begin
            n_bad++; $display("FAIL post_release: state %0d cnt %0d want 0/0", st0, cnt0);
        end
        n_cmp++;
    endtask

    task automatic test_mode0();
        mode = 2'd0; rd_ready = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        if (st0 !== 2'd1) begin n_bad++; $display("FAIL m0_run: got %0d want 1", st0); end
        n_cmp++;
        for (int n = 0; n < 5; n++) begin
            ir = 16'h1000 + 16'(n);
            stop = (n == 4);
            tick();
            if (n == 0) begin
                if (v0 !== 1'b0) begin n_bad++; $display("FAIL m0_latency: valid %b want 0", v0); end
                n_cmp++;
            end else begin
                if (rec0 !== rec(16'(n-1), 1'b0, 1'b0, 16'h1000 + 16'(n-1), 3'd0)) begin
                    n_bad++; $display("FAIL m0_rec%0d: got %h want %h", n-1, rec0,
                                      rec(16'(n-1), 1'b0, 1'b0, 16'h1000 + 16'(n-1), 3'd0));
                end
                n_cmp++;
            end
        end
        stop = 1'b0;
        tick();
        if (rec0 !== rec(16'd4, 1'b0, 1'b0, 16'h1004, 3'd0)) begin
            n_bad++; $display("FAIL m0_rec4: got %h want %h", rec0, rec(16'd4, 1'b0, 1'b0, 16'h1004, 3'd0));
        end
        n_cmp++;
        if (st0 !== 2'd0) begin n_bad++; $display("FAIL m0_idle: got %0d want 0", st0); end
        n_cmp++;
        tick();
        if (v0 !== 1'b0 || cnt0 !== 3'd0) begin
            n_bad++; $display("FAIL m0_empty: valid %b cnt %0d want 0/0", v0, cnt0);
        end
        n_cmp++;
    endtask

    task automatic test_mode1();
        rd_ready = 1'b0; mode = 2'd1; ir = 16'h2222; nzp = 3'b010; start = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 0; n < 10; n++) begin
            nzp = (n >= 4) ? 3'b100 : 3'b010;
            stop = (n == 9);
            tick();
        end
        stop = 1'b0;
        tick();
        if (cnt0 !== 3'd2) begin n_bad++; $display("FAIL m1_count: got %0d want 2", cnt0); end
        n_cmp++;
        if (rec0 !== rec(16'd0, 1'b0, 1'b0, 16'h2222, 3'b010)) begin
            n_bad++; $display("FAIL m1_first: got %h want %h", rec0, rec(16'd0, 1'b0, 1'b0, 16'h2222, 3'b010));
        end
        n_cmp++;
        rd_ready = 1'b1;
        tick();
        if (rec0 !== rec(16'd4, 1'b0, 1'b0, 16'h2222, 3'b100)) begin
            n_bad++; $display("FAIL m1_change: got %h want %h", rec0, rec(16'd4, 1'b0, 1'b0, 16'h2222, 3'b100));
        end
        n_cmp++;
        tick();
        if (cnt0 !== 3'd0) begin n_bad++; $display("FAIL m1_drained: got %0d want 0", cnt0); end
        n_cmp++;
        rd_ready = 1'b0; nzp = 3'd0;
    endtask

    task automatic test_overflow_clear();
        mode = 2'd2; ci = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 0; n < 6; n++) begin
            ci = 1'b1; ir = 16'h3000 + 16'(n);
            tick();
        end
        ci = 1'b0;
        tick();
        if (cnt0 !== 3'd4 || ov0 !== 1'b1) begin
            n_bad++; $display("FAIL ovf_fill: cnt %0d ov %b want 4/1", cnt0, ov0);
        end
        n_cmp++;
        if (dc0 !== 8'd2) begin n_bad++; $display("FAIL ovf_drops: got %0d want 2", dc0); end
        n_cmp++;
        if (st0 !== 2'd1) begin n_bad++; $display("FAIL ovf_state: got %0d want 1", st0); end
        n_cmp++;
        if (st1 !== 2'd2 || dc1 !== 8'd1) begin
            n_bad++; $display("FAIL sof_state: state %0d dc %0d want 2/1", st1, dc1);
        end
        n_cmp++;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        if (cnt0 !== 3'd0 || ov0 !== 1'b0 || dc0 !== 8'd0 || v0 !== 1'b0) begin
            n_bad++; $display("FAIL clear_status: cnt %0d ov %b dc %0d want 0/0/0", cnt0, ov0, dc0);
        end
        n_cmp++;
        if (st0 !== 2'd0 || st1 !== 2'd0) begin
            n_bad++; $display("FAIL clear_state: %0d/%0d want 0/0", st0, st1);
        end
        n_cmp++;
    endtask

    task automatic test_stop_on_full();
        mode = 2'd2; start = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 0; n < 6; n++) begin
            ci = 1'b1; ir = 16'h4000 + 16'(n);
            tick();
            if (n == 4) begin
                if (st1 !== 2'd1) begin n_bad++; $display("FAIL sof_run: got %0d want 1", st1); end
                n_cmp++;
            end
            if (n == 5) begin
                if (st1 !== 2'd2 || dc1 !== 8'd1) begin
                    n_bad++; $display("FAIL sof_stop: state %0d dc %0d want 2/1", st1, dc1);
                end
                n_cmp++;
            end
        end
        ci = 1'b0; rd_ready = 1'b1;
        for (int n = 0; n < 4; n++) begin
            if (rec1 !== rec(16'(n), 1'b0, 1'b1, 16'h4000 + 16'(n), 3'd0)) begin
                n_bad++; $display("FAIL sof_drain%0d: got %h want %h", n, rec1,
                                  rec(16'(n), 1'b0, 1'b1, 16'h4000 + 16'(n), 3'd0));
            end
            n_cmp++;
            tick();
        end
        if (v1 !== 1'b0 || st1 !== 2'd2) begin
            n_bad++; $display("FAIL sof_after: valid %b state %0d want 0/2", v1, st1);
        end
        n_cmp++;
        start = 1'b1;
        tick();
        start = 1'b0;
        if (st1 !== 2'd2) begin n_bad++; $display("FAIL sof_start_ign: got %0d want 2", st1); end
        n_cmp++;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        if (st1 !== 2'd0 || ov1 !== 1'b0) begin
            n_bad++; $display("FAIL sof_clear: state %0d ov %b want 0/0", st1, ov1);
        end
        n_cmp++;
        rd_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        mode = 2'd0; rd_ready = 1'b0; ir = 16'h6000; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        if (cnt0 !== 3'd4 || cnt1 !== 3'd4) begin
            n_bad++; $display("FAIL b2b_full: %0d/%0d want 4/4", cnt0, cnt1);
        end
        n_cmp++;
        rd_ready = 1'b1;
        for (int j = 0; j < 5; j++) begin
            if (rec0 !== rec(16'(j), 1'b0, 1'b0, 16'h6000, 3'd0) || cnt0 !== 3'd4) begin
                n_bad++; $display("FAIL b2b_stream%0d: rec %h cnt %0d want %h/4", j, rec0, cnt0,
                                  rec(16'(j), 1'b0, 1'b0, 16'h6000, 3'd0));
            end
            n_cmp++;
            tick();
        end
        if (ov0 !== 1'b0 || dc0 !== 8'd0 || ov1 !== 1'b0 || st1 !== 2'd1 || cnt1 !== 3'd4) begin
            n_bad++; $display("FAIL b2b_nodrop: ov %b dc %0d ov1 %b st1 %0d cnt1 %0d want 0/0/0/1/4",
                              ov0, dc0, ov1, st1, cnt1);
        end
        n_cmp++;
        stop = 1'b1; start = 1'b1;
        tick();
        stop = 1'b0; start = 1'b0;
        if (st0 !== 2'd0 || st1 !== 2'd0) begin
            n_bad++; $display("FAIL stop_start: %0d/%0d want 0/0", st0, st1);
        end
        n_cmp++;
        for (int i = 0; i < 6; i++) tick();
        if (cnt0 !== 3'd0) begin n_bad++; $display("FAIL b2b_drain: got %0d want 0", cnt0); end
        n_cmp++;
    endtask

    task automatic test_async_reset();
        mode = 2'd0; rd_ready = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        if (cnt0 !== 3'd3 || st0 !== 2'd1) begin
            n_bad++; $display("FAIL ar_pre: cnt %0d state %0d want 3/1", cnt0, st0);
        end
        n_cmp++;
        #2;
        reset = 1'b0;
        #1;
        if (v0 !== 1'b0 || cnt0 !== 3'd0 || st0 !== 2'd0 || rec0 !== 72'h0) begin
            n_bad++; $display("FAIL ar_immediate: valid %b cnt %0d state %0d want 0/0/0", v0, cnt0, st0);
        end
        n_cmp++;
        @(negedge clock);
        reset = 1'b1;
        tick();
        ir = 16'h5000; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        if (rec0 !== rec(16'd0, 1'b0, 1'b0, 16'h5000, 3'd0)) begin
            n_bad++; $display("FAIL ar_restart: got %h want %h", rec0, rec(16'd0, 1'b0, 1'b0, 16'h5000, 3'd0));
        end
        n_cmp++;
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0; rd_ready = 1'b0;
        cd = 1'b0; ci = 1'b0; mode = 2'd0; ir = 16'h0; nzp = 3'd0;
        psr = c_PSR; irx = c_IRX; imem = c_IMEM;
        test_reset();
        test_mode0();
        test_mode1();
        test_overflow_clear();
        test_stop_on_full();
        test_back_to_back();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
